hit_input_fifo: RTL and testbench

//  Upstream feeder for BlockMemoryStorage: buffers incoming (SSID, hitInfo) hits in a circular FIFO
//  and presents them to storage one at a time. Each hand-off is a single-cycle newAddress pulse,

---
 rtl/hit_input_fifo.sv | 96 +++++++++
 tb/tb_hit_input_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hit_input_fifo.sv
// Circular hit buffer in front of BlockMemoryStorage: queues (SSID, hitInfo) pairs and
// hands them to storage one at a time as an ISSUE strobe followed by a HOLDOFF dead cycle.
module hit_input_fifo #(
  parameter int SSIDBITS  = 11,
  parameter int NCOLS_HLM = 16,
  parameter int DEPTH     = 16,
  parameter int ADDRBITS  = 4
) (
  input  logic                 clock,
  input  logic                 clearMemory,
  input  logic                 inValid,
  input  logic [SSIDBITS-1:0]  inSSID,
  input  logic [NCOLS_HLM-1:0] inHitInfo,
  output logic                 inReady,
  input  logic                 storageReady,
  output logic [SSIDBITS-1:0]  SSID,
  output logic [NCOLS_HLM-1:0] hitInfo,
  output logic                 newAddress,
  output logic [ADDRBITS:0]    count,
  output logic                 overflow
);

  localparam logic [ADDRBITS:0] FULL_CNT = (ADDRBITS+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLDOFF} state_t;

  logic [SSIDBITS-1:0]  r_mem_ssid [DEPTH];
  logic [NCOLS_HLM-1:0] r_mem_hit  [DEPTH];
  logic [ADDRBITS-1:0]  r_wr_ptr;
  logic [ADDRBITS-1:0]  r_rd_ptr;
  logic [ADDRBITS:0]    r_count;
  logic                 r_overflow;
  logic [SSIDBITS-1:0]  r_ssid;
  logic [NCOLS_HLM-1:0] r_hit;
  state_t               r_state;
  state_t               w_state_nxt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // full/empty come from the registered count, so a pop never frees space for a same-cycle push
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_push  = inValid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && storageReady && !w_empty;

  assign inReady    = !w_full;
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign SSID       = r_ssid;
  assign hitInfo    = r_hit;
  assign newAddress = (r_state == S_ISSUE);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_ssid[r_wr_ptr] <= inSSID;
      r_mem_hit[r_wr_ptr]  <= inHitInfo;
    end
  end

  always_ff @(posedge clock) begin
    if (clearMemory) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_ssid     <= '0;
      r_hit      <= '0;
      r_state    <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDRBITS'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDRBITS'(1);
        r_ssid   <= r_mem_ssid[r_rd_ptr];
        r_hit    <= r_mem_hit[r_rd_ptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + (ADDRBITS+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (ADDRBITS+1)'(1);
      if (inValid && w_full) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hit_input_fifo.sv
// Directed bench for hit_input_fifo: reset, single hit latency, fill/overflow, drain order,
// continuous streaming against a reference queue, mid-strobe reset and storageReady backpressure.
module tb_hit_input_fifo;

  logic        clock = 1'b0;
  logic        clearMemory;
  logic        inValid;
  logic [10:0] inSSID;
  logic [15:0] inHitInfo;
  logic        inReady;
  logic        storageReady;
  logic [10:0] SSID;
  logic [15:0] hitInfo;
  logic        newAddress;
  logic [4:0]  count;
  logic        overflow;

  int nerr = 0;
  int nchk = 0;

  hit_input_fifo #(.SSIDBITS(11), .NCOLS_HLM(16), .DEPTH(16), .ADDRBITS(4)) dut (
    .clock(clock), .clearMemory(clearMemory), .inValid(inValid), .inSSID(inSSID),
    .inHitInfo(inHitInfo), .inReady(inReady), .storageReady(storageReady), .SSID(SSID),
    .hitInfo(hitInfo), .newAddress(newAddress), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clearMemory = 1'b1; inValid = 1'b0; storageReady = 1'b0;
    tick();
    clearMemory = 1'b0;
  endtask

  task automatic test_reset();
    inSSID = 11'd0; inHitInfo = 16'd0;
    do_reset();
    nchk++; if (count !== 5'd0) begin nerr++; $display("FAIL reset_count got=%0d exp=0", count); end
    nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL reset_newAddress got=%b exp=0", newAddress); end
    nchk++; if (SSID !== 11'd0) begin nerr++; $display("FAIL reset_SSID got=%0d exp=0", SSID); end
    nchk++; if (hitInfo !== 16'd0) begin nerr++; $display("FAIL reset_hitInfo got=%h exp=0000", hitInfo); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    nchk++; if (inReady !== 1'b1) begin nerr++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
  endtask

  task automatic test_single_hit();
    storageReady = 1'b1; inValid = 1'b1; inSSID = 11'd5; inHitInfo = 16'hA5A5;
    tick();
    inValid = 1'b0;
    nchk++; if (count !== 5'd1) begin nerr++; $display("FAIL single_count1 got=%0d exp=1", count); end
    nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL single_early_strobe got=%b exp=0", newAddress); end
    tick();
    nchk++; if (newAddress !== 1'b1) begin nerr++; $display("FAIL single_strobe got=%b exp=1", newAddress); end
    nchk++; if (SSID !== 11'd5) begin nerr++; $display("FAIL single_SSID got=%0d exp=5", SSID); end
    nchk++; if (hitInfo !== 16'hA5A5) begin nerr++; $display("FAIL single_hitInfo got=%h exp=a5a5", hitInfo); end
    nchk++; if (count !== 5'd0) begin nerr++; $display("FAIL single_count0 got=%0d exp=0", count); end
    tick();
    nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL single_strobe_len got=%b exp=0", newAddress); end
    nchk++; if (SSID !== 11'd5) begin nerr++; $display("FAIL single_hold got=%0d exp=5", SSID); end
    tick();
  endtask

  task automatic test_fill_overflow();
    storageReady = 1'b0;
    for (int i = 0; i < 16; i++) begin
      inValid = 1'b1; inSSID = 11'(i); inHitInfo = 16'(i * 257);
      tick();
    end
    nchk++; if (count !== 5'd16) begin nerr++; $display("FAIL fill_count got=%0d exp=16", count); end
    nchk++; if (inReady !== 1'b0) begin nerr++; $display("FAIL fill_inReady got=%b exp=0", inReady); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL fill_no_overflow got=%b exp=0", overflow); end
    inSSID = 11'd99;
    tick();
    inValid = 1'b0;
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    nchk++; if (count !== 5'd16) begin nerr++; $display("FAIL fill_count_held got=%0d exp=16", count); end
  endtask

  task automatic test_drain();
    storageReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      nchk++; if (newAddress !== 1'b1) begin nerr++; $display("FAIL drain_strobe[%0d] got=%b exp=1", i, newAddress); end
      nchk++; if (SSID !== 11'(i)) begin nerr++; $display("FAIL drain_SSID[%0d] got=%0d exp=%0d", i, SSID, i); end
      nchk++; if (hitInfo !== 16'(i * 257)) begin nerr++; $display("FAIL drain_hit[%0d] got=%h exp=%h", i, hitInfo, 16'(i * 257)); end
      nchk++; if (count !== 5'(15 - i)) begin nerr++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 15 - i); end
      tick();
      nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL drain_gap1[%0d] got=%b exp=0", i, newAddress); end
      tick();
      nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL drain_gap2[%0d] got=%b exp=0", i, newAddress); end
    end
    tick();
    nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL drain_extra got=%b exp=0", newAddress); end
    nchk++; if (count !== 5'd0) begin nerr++; $display("FAIL drain_empty got=%0d exp=0", count); end
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL drain_overflow_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_stream();
    logic [10:0] q[$];
    logic [10:0] mout;
    int mcnt;
    int mst;
    bit acc;
    bit pop;
    do_reset();
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL stream_ovf_cleared got=%b exp=0", overflow); end
    mcnt = 0; mst = 0; mout = 11'd0;
    storageReady = 1'b1;
    for (int c = 0; c < 40; c++) begin
      inValid = 1'b1; inSSID = 11'(100 + c); inHitInfo = 16'(c);
      #1;
      nchk++; if (inReady !== (mcnt < 16)) begin nerr++; $display("FAIL stream_inReady[%0d] got=%b exp=%b", c, inReady, mcnt < 16); end
      nchk++; if (newAddress !== (mst == 1)) begin nerr++; $display("FAIL stream_strobe[%0d] got=%b exp=%b", c, newAddress, mst == 1); end
      if (mst == 1) begin
        nchk++; if (SSID !== mout) begin nerr++; $display("FAIL stream_SSID[%0d] got=%0d exp=%0d", c, SSID, mout); end
      end
      acc = (mcnt < 16);
      pop = (mst == 0) && (mcnt > 0);
      if (pop) mout = q.pop_front();
      if (acc) q.push_back(11'(100 + c));
      mcnt = mcnt + int'(acc) - int'(pop);
      mst = pop ? 1 : ((mst == 1) ? 2 : 0);
      tick();
      nchk++; if (count !== 5'(mcnt)) begin nerr++; $display("FAIL stream_count[%0d] got=%0d exp=%0d", c, count, mcnt); end
    end
    inValid = 1'b0;
    nchk++; if (count !== 5'd16) begin nerr++; $display("FAIL stream_saturate got=%0d exp=16", count); end
    nchk++; if (overflow !== 1'b1) begin nerr++; $display("FAIL stream_overflow got=%b exp=1", overflow); end
  endtask

  task automatic test_reset_in_issue();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; inSSID = 11'(40 + i); inHitInfo = 16'hBEEF;
      tick();
    end
    inValid = 1'b0; storageReady = 1'b1;
    tick();
    nchk++; if (newAddress !== 1'b1 || count !== 5'd3) begin
      nerr++; $display("FAIL rst_issue_setup got=%b/%0d exp=1/3", newAddress, count);
    end
    clearMemory = 1'b1;
    tick();
    clearMemory = 1'b0;
    nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL rst_issue_strobe got=%b exp=0", newAddress); end
    nchk++; if (count !== 5'd0) begin nerr++; $display("FAIL rst_issue_count got=%0d exp=0", count); end
    nchk++; if (SSID !== 11'd0) begin nerr++; $display("FAIL rst_issue_SSID got=%0d exp=0", SSID); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_issue_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 6; i++) begin
      tick();
      nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL rst_issue_quiet[%0d] got=%b exp=0", i, newAddress); end
    end
  endtask

  task automatic test_holdoff_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1; inSSID = 11'(20 + i); inHitInfo = 16'(i);
      tick();
    end
    inValid = 1'b0; storageReady = 1'b1;
    tick();
    nchk++; if (newAddress !== 1'b1 || SSID !== 11'd20) begin
      nerr++; $display("FAIL bp_first got=%b/%0d exp=1/20", newAddress, SSID);
    end
    tick();
    storageReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nchk++; if (newAddress !== 1'b0) begin nerr++; $display("FAIL bp_stalled[%0d] got=%b exp=0", i, newAddress); end
    end
    nchk++; if (count !== 5'd2) begin nerr++; $display("FAIL bp_count got=%0d exp=2", count); end
    storageReady = 1'b1;
    tick();
    nchk++; if (newAddress !== 1'b1) begin nerr++; $display("FAIL bp_resume got=%b exp=1", newAddress); end
    nchk++; if (SSID !== 11'd21) begin nerr++; $display("FAIL bp_resume_SSID got=%0d exp=21", SSID); end
  endtask

  initial begin
    clearMemory = 1'b0; inValid = 1'b0; storageReady = 1'b0;
    inSSID = 11'd0; inHitInfo = 16'd0;
    #2;
    test_reset();
    test_single_hit();
    test_fill_overflow();
    test_drain();
    test_stream();
    test_reset_in_issue();
    test_holdoff_backpressure();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
